// File: rtl/color_region_stats.sv
// color_region_stats: per-frame color-dominance match count and bounding box
// over the active pixel stream, published as a snapshot plus a one-cycle strobe.
module color_region_stats #(
  parameter int                 H_ACTIVE = 640,
  parameter int                 V_ACTIVE = 480,
  parameter logic signed [25:0] THRESH   = 26'sd82906
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ctrl,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  output logic        stat_valid,
  output logic        stat_found,
  output logic [19:0] stat_count,
  output logic [9:0]  stat_xmin,
  output logic [9:0]  stat_xmax,
  output logic [9:0]  stat_ymin,
  output logic [9:0]  stat_ymax,
  output logic        frame_err
);

  typedef enum logic [1:0] {
    S_IDLE, S_ACTIVE, S_FLUSH, S_PUBLISH
  } state_t;

  state_t      r_state, w_next;
  logic        r_pending, r_flush, r_err;
  logic [1:0]  r_ctrl, w_sel;
  logic [1:0]  r_tag, w_ptag, r_pub_tag;
  logic [3:0]  r_live;
  logic [9:0]  r_x, r_y, w_px, w_py;
  logic        w_run, w_start, w_accept;
  logic        w_abort, w_last;

  // A frame is open in ACTIVE, or once a new sof
  // has arrived while the previous frame drains.
  assign w_run    = (r_state == S_ACTIVE) || r_pending;
  assign w_start  = in_valid && in_sof;
  assign w_accept = in_valid && (in_sof || w_run);
  assign w_abort  = w_start && w_run;
  assign w_px     = in_sof ? '0 : r_x;
  assign w_py     = in_sof ? '0 : r_y;
  assign w_last   = w_accept && !r_pending
                 && (w_px == 10'(H_ACTIVE - 1))
                 && (w_py == 10'(V_ACTIVE - 1));
  assign w_ptag   = w_start ? r_tag + 2'd1 : r_tag;
  assign w_sel    = w_start ? ctrl : r_ctrl;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_start) w_next = w_last ? S_FLUSH : S_ACTIVE;
      S_ACTIVE:  if (w_last) w_next = S_FLUSH;
      S_FLUSH:   if (r_flush) w_next = S_PUBLISH;
      S_PUBLISH: w_next = (r_pending || w_start) ? S_ACTIVE : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pending <= 1'b0;
      r_flush   <= 1'b0;
      r_err     <= 1'b0;
      r_ctrl    <= 2'b00;
      r_tag     <= 2'd0;
      r_pub_tag <= 2'd0;
      r_live    <= 4'b0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      r_state   <= w_next;
      r_err     <= w_abort;
      r_flush   <= (r_state == S_FLUSH) && !r_flush;
      r_pending <= (r_state == S_FLUSH) && (r_pending || w_start);
      if (w_accept) begin
        if (w_px == 10'(H_ACTIVE - 1)) begin
          r_x <= '0;
          r_y <= w_py + 10'd1;
        end else begin
          r_x <= w_px + 10'd1;
          r_y <= w_py;
        end
      end
      if (w_abort) r_live[r_tag] <= 1'b0;
      if (w_start) begin
        r_ctrl         <= ctrl;
        r_tag          <= w_ptag;
        r_live[w_ptag] <= 1'b1;
      end
      if (w_last) r_pub_tag <= w_ptag;
    end
  end

  // P1: select channels, register pixel tag/coords and differences
  logic [7:0]        w_c, w_a, w_b;
  logic signed [8:0] w_d1, w_d2;

  always_comb begin
    w_c = in_r;
    w_a = in_g;
    w_b = in_b;
    case (w_sel)
      2'b01: begin w_c = in_g; w_a = in_r; w_b = in_b; end
      2'b10: begin w_c = in_b; w_a = in_r; w_b = in_g; end
      default: ;
    endcase
  end

  assign w_d1 = $signed({1'b0, w_c}) - $signed({1'b0, w_a});
  assign w_d2 = $signed({1'b0, w_c}) - $signed({1'b0, w_b});

  logic              r_p1_v, r_p1_en;
  logic [1:0]        r_p1_tag;
  logic [9:0]        r_p1_x, r_p1_y;
  logic [7:0]        r_p1_c;
  logic signed [8:0] r_p1_d1, r_p1_d2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p1_v   <= 1'b0;
      r_p1_en  <= 1'b0;
      r_p1_tag <= 2'd0;
      r_p1_x   <= '0;
      r_p1_y   <= '0;
      r_p1_c   <= '0;
      r_p1_d1  <= '0;
      r_p1_d2  <= '0;
    end else begin
      r_p1_v   <= w_accept;
      r_p1_en  <= (w_sel != 2'b11);
      r_p1_tag <= w_ptag;
      r_p1_x   <= w_px;
      r_p1_y   <= w_py;
      r_p1_c   <= w_c;
      r_p1_d1  <= w_d1;
      r_p1_d2  <= w_d2;
    end
  end

  // P2: c*(c-a)*(c-b); magnitude stays below 2^25
  logic signed [25:0] w_cx, w_d1x, w_d2x, w_prod;
  assign w_cx   = 26'($signed({1'b0, r_p1_c}));
  assign w_d1x  = 26'(r_p1_d1);
  assign w_d2x  = 26'(r_p1_d2);
  assign w_prod = w_cx * w_d1x * w_d2x;

  logic               r_p2_v, r_p2_en;
  logic [1:0]         r_p2_tag;
  logic [9:0]         r_p2_x, r_p2_y;
  logic signed [25:0] r_p2_prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p2_v    <= 1'b0;
      r_p2_en   <= 1'b0;
      r_p2_tag  <= 2'd0;
      r_p2_x    <= '0;
      r_p2_y    <= '0;
      r_p2_prod <= '0;
    end else begin
      r_p2_v    <= r_p1_v;
      r_p2_en   <= r_p1_en;
      r_p2_tag  <= r_p1_tag;
      r_p2_x    <= r_p1_x;
      r_p2_y    <= r_p1_y;
      r_p2_prod <= w_prod;
    end
  end

  // P3: one accumulator bank per tag keeps a draining frame
  // separate from the next one and squashes aborted pixels.
  logic [19:0] r_cnt  [4];
  logic [9:0]  r_xmin [4];
  logic [9:0]  r_xmax [4];
  logic [9:0]  r_ymin [4];
  logic [9:0]  r_ymax [4];
  logic        w_hit;

  assign w_hit = r_p2_v && r_p2_en && r_live[r_p2_tag]
              && (r_p2_prod > THRESH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i]  <= '0;
        r_xmin[i] <= '1;
        r_xmax[i] <= '0;
        r_ymin[i] <= '1;
        r_ymax[i] <= '0;
      end
    end else begin
      if (w_hit) begin
        r_cnt[r_p2_tag] <= r_cnt[r_p2_tag] + 20'd1;
        if (r_p2_x < r_xmin[r_p2_tag]) r_xmin[r_p2_tag] <= r_p2_x;
        if (r_p2_x > r_xmax[r_p2_tag]) r_xmax[r_p2_tag] <= r_p2_x;
        if (r_p2_y < r_ymin[r_p2_tag]) r_ymin[r_p2_tag] <= r_p2_y;
        if (r_p2_y > r_ymax[r_p2_tag]) r_ymax[r_p2_tag] <= r_p2_y;
      end
      if (w_start) begin
        r_cnt[w_ptag]  <= '0;
        r_xmin[w_ptag] <= '1;
        r_xmax[w_ptag] <= '0;
        r_ymin[w_ptag] <= '1;
        r_ymax[w_ptag] <= '0;
      end
    end
  end

  logic [19:0] w_pcnt;
  logic        w_pfound;
  assign w_pcnt   = r_cnt[r_pub_tag];
  assign w_pfound = |w_pcnt;

  logic        r_sv, r_found;
  logic [19:0] r_count;
  logic [9:0]  r_sxmin, r_sxmax, r_symin, r_symax;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sv    <= 1'b0;
      r_found <= 1'b0;
      r_count <= '0;
      r_sxmin <= '0;
      r_sxmax <= '0;
      r_symin <= '0;
      r_symax <= '0;
    end else begin
      r_sv <= (r_state == S_PUBLISH);
      if (r_state == S_PUBLISH) begin
        r_found <= w_pfound;
        r_count <= w_pcnt;
        r_sxmin <= w_pfound ? r_xmin[r_pub_tag] : '0;
        r_sxmax <= w_pfound ? r_xmax[r_pub_tag] : '0;
        r_symin <= w_pfound ? r_ymin[r_pub_tag] : '0;
        r_symax <= w_pfound ? r_ymax[r_pub_tag] : '0;
      end
    end
  end

  assign stat_valid = r_sv;
  assign stat_found = r_found;
  assign stat_count = r_count;
  assign stat_xmin  = r_sxmin;
  assign stat_xmax  = r_sxmax;
  assign stat_ymin  = r_symin;
  assign stat_ymax  = r_symax;
  assign frame_err  = r_err;

endmodule

// File: doc/color_region_stats.md
# color_region_stats

Per-frame statistics engine on the camera pixel stream, placed after the color-highlight filter. It applies the same color-dominance test to every active pixel and accumulates per-frame results: match count and bounding box of matching pixels. Results go out once per frame as a registered snapshot plus a one-cycle strobe, for the overlay/HUD logic and the HPS readout.

## Interface

- `H_ACTIVE`, 640, active pixels per line
- `V_ACTIVE`, 480, active lines per frame
- `THRESH`, 26'sd82906 (0x143DA), dominance threshold; match when metric > THRESH (strict)

- `clk` in 1: pixel clock
- `rst` in 1: asynchronous, active-high reset
- `ctrl` in 2: 00 red, 01 green, 10 blue, 11 disabled (no pixel matches); sampled only on an accepted `in_sof` pixel
- `in_valid` in 1: pixel qualifier; `in_r/g/b` and `in_sof` are ignored when low
- `in_sof` in 1: marks the pixel as (x=0,y=0) of a new frame
- `in_r`, `in_g`, `in_b` in 8 each: unsigned pixel components
- `stat_valid` out 1: one-cycle strobe; snapshot outputs are updated in the same cycle
- `stat_found` out 1: snapshot contains at least one match
- `stat_count` out 20: number of matching pixels
- `stat_xmin`, `stat_xmax` out 10 each: bounding-box columns
- `stat_ymin`, `stat_ymax` out 10 each: bounding-box rows
- `frame_err` out 1: one-cycle strobe when a frame is aborted

## Operation

- Dominance metric for the selected color c against the others a, b: c*(c-a)*(c-b).
  - Differences are signed 9-bit.
  - The product is signed 26-bit; it cannot overflow (|max| = 255*255*255 < 2^25).
  - Compare is signed against THRESH.
- Coordinates:
  - x counts 0..H_ACTIVE-1 on accepted pixels.
  - At wrap, x goes to 0 and y increments.
  - Coordinates advance only when `in_valid`=1.
- Accumulators: count, xmin, xmax, ymin, ymax.
  - Cleared on an accepted sof: count=0, min=all-ones, max=0.
  - Each matching pixel increments count and updates min/max.
- FSM:
  - IDLE: pixels are ignored until `in_valid && in_sof`. On that pixel, latch `ctrl`, clear the accumulators, process the pixel as (0,0), and go to ACTIVE.
  - ACTIVE: process pixels.
    - `in_valid && in_sof` arriving before the last pixel is an aborted frame. Pulse `frame_err`, discard the accumulators, restart as a fresh frame at (0,0) with the new `ctrl`, and stay in ACTIVE.
    - Accepting pixel (H_ACTIVE-1, V_ACTIVE-1) moves to FLUSH.
  - FLUSH: wait for the pipeline to drain (2 cycles), then go to PUBLISH.
    - Pixels accepted here without sof are ignored.
    - An sof in FLUSH is accepted: the finished frame still publishes and the new frame starts; both use separate pipeline tags.
  - PUBLISH (1 cycle): copy the accumulators to the snapshot registers and pulse `stat_valid`. Then go to IDLE, or to ACTIVE if a new frame has already started.
- Extra pixels after the last pixel without sof are ignored (no coordinate advance, no accumulation).
- Snapshot registers hold their values until the next PUBLISH. An aborted frame never changes them.
- If count=0 at publish: `stat_found`=0, and the min/max outputs report 0.
- `ctrl`=11: the frame still publishes, with count=0 and `stat_found`=0.

## Timing

- Reset (async assert, released synchronously to `clk`):
  - FSM in IDLE.
  - All outputs 0: `stat_valid`, `stat_found`, `stat_count`, `stat_x/ymin`, `stat_x/ymax`, `frame_err`.
  - Accumulators cleared.
- Pipeline (no backpressure; one pixel per clock max):
  - P1: register the pixel, coordinates and frame tag; compute differences.
  - P2: product.
  - P3: compare and accumulator update.
- Last pixel accepted at cycle N: `stat_valid`=1 at cycle N+4, for exactly 1 cycle.
- `frame_err` asserts the cycle after the offending sof is accepted, for 1 cycle. Pixels of the aborted frame still in the pipeline are squashed by their tag.
- Reset mid-frame: all state is lost, no strobe is issued, and the block waits for a new sof.
- Gaps in `in_valid` stretch the frame; the statistics are unaffected.

## Test plan

Benches use H_ACTIVE=4, V_ACTIVE=3, 12 pixels/frame.

- Reset, then a frame of all (0,0,0) with `ctrl`=00: `stat_valid` pulse 4 cycles after the last pixel; count=0, found=0, min/max=0.
- `ctrl`=00, pure red (255,0,0) at (1,0) and (3,2), all others gray (100,100,100): count=2, xmin=1, xmax=3, ymin=0, ymax=2, found=1.
- Threshold edge, `ctrl`=01: pixel g=200, r=b=194 gives 200*6*6=7200, no match. Pixel (0,255,80) gives 255*255*175=11379375, match. Expect count=1.
- Abort: sof again after 7 pixels. Expect a `frame_err` pulse, no `stat_valid` for the aborted frame, and the following full frame publishes correctly.
- `in_valid` toggling every other cycle, plus 3 extra pixels after the last pixel: same stats as the contiguous run, and the extra pixels are ignored.
- Assert `rst` mid-frame: outputs go to 0 immediately, and no strobe follows until a new complete frame.
